// File: rtl/scr1_pipe_mprf_wb_pkg.sv
// Shared architectural definitions for the multi-port register-file
// writeback path.
//   SCR1_XLEN         : integer register width
//   SCR1_MPRF_AWIDTH  : register address width
//   type_scr1_wb_entry_s : one queued writeback {addr, data}
package scr1_pipe_mprf_wb_pkg;

    localparam int unsigned SCR1_XLEN        = 32;
    localparam int unsigned SCR1_MPRF_AWIDTH = 5;

    typedef struct packed {
        logic [SCR1_MPRF_AWIDTH-1:0] addr;
        logic [SCR1_XLEN-1:0]        data;
    } type_scr1_wb_entry_s;

endpackage : scr1_pipe_mprf_wb_pkg

// File: rtl/scr1_pipe_mprf_wb_chk.sv
// Protocol checker for the writeback block (simulation assertions only).
// Ports: observes the LSU/load-issue inputs plus the block's internal
// occupancy, push/pop decisions and load-pending bitmap.
module scr1_pipe_mprf_wb_chk
    import scr1_pipe_mprf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_lsu_req,
    input  logic [SCR1_MPRF_AWIDTH-1:0] i_lsu_addr,
    input  logic                        i_ld_issue,
    input  logic [SCR1_MPRF_AWIDTH-1:0] i_ld_addr,
    input  logic                        i_lsu_push,
    input  logic                        i_alu_push,
    input  logic                        i_pop,
    input  logic [$clog2(DEPTH+1)-1:0]  i_count,
    input  logic [SCR1_XLEN-1:0]        i_pend
);

    // An LSU return must always find room once the same-edge pop is counted.
    a_lsu_fits: assert property (@(posedge clk) disable iff (!rst_n)
        i_lsu_push |-> ((int'(i_count) - int'(i_pop) + 1 + int'(i_alu_push)) <= DEPTH));

    // Load data may only come back for a register with a load outstanding.
    a_lsu_pending: assert property (@(posedge clk) disable iff (!rst_n)
        (i_lsu_req && (i_lsu_addr != 5'd0)) |-> i_pend[i_lsu_addr]);

    // A second load to an outstanding register is illegal unless the first returns now.
    a_ld_double: assert property (@(posedge clk) disable iff (!rst_n)
        (i_ld_issue && (i_ld_addr != 5'd0) && !(i_lsu_req && (i_lsu_addr == i_ld_addr)))
            |-> !i_pend[i_ld_addr]);

endmodule : scr1_pipe_mprf_wb_chk

// File: rtl/scr1_pipe_mprf_wb_fifo.sv
// In-order writeback queue with two push ports and one pop port.
// Push port 0 is always placed ahead of push port 1 when both fire.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_push0_vld/_entry    : first push (LSU side)
//   i_push1_vld/_entry    : second push (ALU side)
//   i_pop                 : remove head entry at this edge
//   i_lkp1/2_addr         : addresses looked up against valid entries
//   o_head                : head entry (meaningful when o_count != 0)
//   o_count               : registered occupancy
//   o_lkp1/2_hit          : some valid entry targets the lookup address
module scr1_pipe_mprf_wb_fifo
    import scr1_pipe_mprf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_push0_vld,
    input  type_scr1_wb_entry_s               i_push0_entry,
    input  logic                              i_push1_vld,
    input  type_scr1_wb_entry_s               i_push1_entry,
    input  logic                              i_pop,
    input  logic [SCR1_MPRF_AWIDTH-1:0]       i_lkp1_addr,
    input  logic [SCR1_MPRF_AWIDTH-1:0]       i_lkp2_addr,
    output type_scr1_wb_entry_s               o_head,
    output logic [$clog2(DEPTH+1)-1:0]        o_count,
    output logic                              o_lkp1_hit,
    output logic                              o_lkp2_hit
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    type_scr1_wb_entry_s r_mem [DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;

    logic [PW-1:0]       w_wptr_p1;
    logic [PW-1:0]       w_wptr_p2;
    logic [PW-1:0]       w_wptr_nxt;
    logic [CW-1:0]       w_push_num;
    type_scr1_wb_entry_s w_first_entry;
    logic [DEPTH-1:0]    w_vld;

    // Pointer increment wrapping at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] res;
        if (ptr == PW'(DEPTH-1)) begin
            res = {PW{1'b0}};
        end else begin
            res = ptr + PW'(1);
        end
        return res;
    endfunction

    // Slot selection: the lone push (or push 0 of a pair) lands at r_wptr.
    always_comb begin
        w_wptr_p1     = ptr_inc(r_wptr);
        w_wptr_p2     = ptr_inc(w_wptr_p1);
        w_push_num    = CW'(i_push0_vld) + CW'(i_push1_vld);
        w_first_entry = i_push0_vld ? i_push0_entry : i_push1_entry;
        case (w_push_num)
            CW'(0):  w_wptr_nxt = r_wptr;
            CW'(1):  w_wptr_nxt = w_wptr_p1;
            CW'(2):  w_wptr_nxt = w_wptr_p2;
            default: w_wptr_nxt = r_wptr;
        endcase
    end

    // Entry storage; deliberately not reset, occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (i_push0_vld | i_push1_vld) begin
            r_mem[r_wptr] <= w_first_entry;
        end
        if (i_push0_vld & i_push1_vld) begin
            r_mem[w_wptr_p1] <= i_push1_entry;
        end
    end

    // Control state: pointers and occupancy. A same-edge pop frees its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= i_pop ? ptr_inc(r_rptr) : r_rptr;
            r_count <= r_count + w_push_num - CW'(i_pop);
        end
    end

    // Valid-entry map: slot i is live if its distance from the head is below the count.
    always_comb begin
        w_vld = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_vld[i] = (((i >= int'(r_rptr)) ? (i - int'(r_rptr))
                                             : (i + DEPTH - int'(r_rptr))) < int'(r_count));
        end
    end

    // Hazard lookup against every live entry.
    always_comb begin
        o_lkp1_hit = 1'b0;
        o_lkp2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_lkp1_hit = o_lkp1_hit | (w_vld[i] & (r_mem[i].addr == i_lkp1_addr));
            o_lkp2_hit = o_lkp2_hit | (w_vld[i] & (r_mem[i].addr == i_lkp2_addr));
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule : scr1_pipe_mprf_wb_fifo

// File: rtl/scr1_pipe_mprf_wb.sv
// Register-file writeback arbiter: queues ALU and LSU results in order,
// drains one entry per cycle into the register file and reports operand
// hazards for the instruction in decode.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   alu_wb_req/addr/data_i, rdy_o   : ALU/CSR result, accepted when rdy_o high
//   lsu_wb_req/addr/data_i          : load data return, never stalled
//   ld_issue_i, ld_issue_addr_i     : load issued, reserves its destination
//   rs1/rs2_addr_i, rs1/rs2_hazard_o: decode operand hazard lookup
//   mprf_w_req_o, rd_addr/data_o    : register-file write port
module scr1_pipe_mprf_wb
    import scr1_pipe_mprf_wb_pkg::*;
#(
    parameter int WB_FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_wb_req_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] alu_wb_addr_i,
    input  logic [SCR1_XLEN-1:0]        alu_wb_data_i,
    output logic                        alu_wb_rdy_o,
    input  logic                        lsu_wb_req_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] lsu_wb_addr_i,
    input  logic [SCR1_XLEN-1:0]        lsu_wb_data_i,
    input  logic                        ld_issue_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] ld_issue_addr_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] rs1_addr_i,
    input  logic [SCR1_MPRF_AWIDTH-1:0] rs2_addr_i,
    output logic                        rs1_hazard_o,
    output logic                        rs2_hazard_o,
    output logic                        mprf_w_req_o,
    output logic [SCR1_MPRF_AWIDTH-1:0] mprf_rd_addr_o,
    output logic [SCR1_XLEN-1:0]        mprf_rd_data_o
);

    localparam int CW = $clog2(WB_FIFO_DEPTH+1);

    logic [SCR1_XLEN-1:0] r_ld_pend;

    logic                 w_alu_rdy;
    logic                 w_alu_push;
    logic                 w_lsu_push;
    logic                 w_pop;
    logic [CW-1:0]        w_count;
    type_scr1_wb_entry_s  w_head;
    type_scr1_wb_entry_s  w_alu_entry;
    type_scr1_wb_entry_s  w_lsu_entry;
    logic                 w_lkp1_hit;
    logic                 w_lkp2_hit;
    logic [SCR1_XLEN-1:0] w_pend_set;
    logic [SCR1_XLEN-1:0] w_pend_clr;
    logic [SCR1_XLEN-1:0] w_pend_nxt;

    // Admission and drain. ALU needs two free slots so a concurrent LSU return
    // always fits; writes to x0 are acknowledged but never queued.
    always_comb begin
        w_alu_rdy        = (w_count <= CW'(WB_FIFO_DEPTH-2));
        w_alu_push       = alu_wb_req_i & w_alu_rdy & (alu_wb_addr_i != 5'd0);
        w_lsu_push       = lsu_wb_req_i & (lsu_wb_addr_i != 5'd0);
        w_pop            = (w_count != {CW{1'b0}});
        w_alu_entry.addr = alu_wb_addr_i;
        w_alu_entry.data = alu_wb_data_i;
        w_lsu_entry.addr = lsu_wb_addr_i;
        w_lsu_entry.data = lsu_wb_data_i;
    end

    scr1_pipe_mprf_wb_fifo #(
        .DEPTH         (WB_FIFO_DEPTH)
    ) i_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push0_vld   (w_lsu_push),
        .i_push0_entry (w_lsu_entry),
        .i_push1_vld   (w_alu_push),
        .i_push1_entry (w_alu_entry),
        .i_pop         (w_pop),
        .i_lkp1_addr   (rs1_addr_i),
        .i_lkp2_addr   (rs2_addr_i),
        .o_head        (w_head),
        .o_count       (w_count),
        .o_lkp1_hit    (w_lkp1_hit),
        .o_lkp2_hit    (w_lkp2_hit)
    );

    // Load-pending bitmap update; a new issue overrides a same-edge return.
    always_comb begin
        w_pend_clr = lsu_wb_req_i ? (32'd1 << lsu_wb_addr_i) : 32'd0;
        w_pend_set = (ld_issue_i && (ld_issue_addr_i != 5'd0)) ? (32'd1 << ld_issue_addr_i) : 32'd0;
        w_pend_nxt = (r_ld_pend & ~w_pend_clr) | w_pend_set;
    end

    // Load-pending bitmap register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_pend <= 32'd0;
        end else begin
            r_ld_pend <= w_pend_nxt;
        end
    end

    // Outputs derive only from registered state (plus the decode addresses for
    // hazards); address/data are forced to zero while the queue is empty so the
    // unreset storage never shows through.
    always_comb begin
        alu_wb_rdy_o   = w_alu_rdy;
        mprf_w_req_o   = w_pop;
        mprf_rd_addr_o = w_pop ? w_head.addr : 5'd0;
        mprf_rd_data_o = w_pop ? w_head.data : 32'd0;
        rs1_hazard_o   = (rs1_addr_i != 5'd0) & (r_ld_pend[rs1_addr_i] | w_lkp1_hit);
        rs2_hazard_o   = (rs2_addr_i != 5'd0) & (r_ld_pend[rs2_addr_i] | w_lkp2_hit);
    end

    scr1_pipe_mprf_wb_chk #(
        .DEPTH      (WB_FIFO_DEPTH)
    ) i_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_lsu_req  (lsu_wb_req_i),
        .i_lsu_addr (lsu_wb_addr_i),
        .i_ld_issue (ld_issue_i),
        .i_ld_addr  (ld_issue_addr_i),
        .i_lsu_push (w_lsu_push),
        .i_alu_push (w_alu_push),
        .i_pop      (w_pop),
        .i_count    (w_count),
        .i_pend     (r_ld_pend)
    );

endmodule : scr1_pipe_mprf_wb

// File: tb/tb_scr1_pipe_mprf_wb.sv
// Bench for scr1_pipe_mprf_wb: directed vectors, a queue/bitmap reference
// model compared every cycle, and literal expectations per scenario.
module tb_scr1_pipe_mprf_wb;
    import scr1_pipe_mprf_wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_wb_req_i;
    logic [4:0]  alu_wb_addr_i;
    logic [31:0] alu_wb_data_i;
    logic        alu_wb_rdy_o;
    logic        lsu_wb_req_i;
    logic [4:0]  lsu_wb_addr_i;
    logic [31:0] lsu_wb_data_i;
    logic        ld_issue_i;
    logic [4:0]  ld_issue_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_hazard_o;
    logic        rs2_hazard_o;
    logic        mprf_w_req_o;
    logic [4:0]  mprf_rd_addr_o;
    logic [31:0] mprf_rd_data_o;

    int checks = 0;
    int errors = 0;

    type_scr1_wb_entry_s m_q[$];     // expected queue contents, head first
    logic [31:0]         m_pend;     // expected outstanding loads
    type_scr1_wb_entry_s w_log[$];   // register writes observed from the DUT

    scr1_pipe_mprf_wb #(.WB_FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_wb_req_i    (alu_wb_req_i),
        .alu_wb_addr_i   (alu_wb_addr_i),
        .alu_wb_data_i   (alu_wb_data_i),
        .alu_wb_rdy_o    (alu_wb_rdy_o),
        .lsu_wb_req_i    (lsu_wb_req_i),
        .lsu_wb_addr_i   (lsu_wb_addr_i),
        .lsu_wb_data_i   (lsu_wb_data_i),
        .ld_issue_i      (ld_issue_i),
        .ld_issue_addr_i (ld_issue_addr_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rs1_hazard_o    (rs1_hazard_o),
        .rs2_hazard_o    (rs2_hazard_o),
        .mprf_w_req_o    (mprf_w_req_o),
        .mprf_rd_addr_o  (mprf_rd_addr_o),
        .mprf_rd_data_o  (mprf_rd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input int idx, input logic [4:0] a, input logic [31:0] d);
        checks++;
        if (idx >= w_log.size()) begin
            errors++;
            $display("FAIL %s actual=missing-write expected=x%0d:%h", name, a, d);
        end else if (w_log[idx].addr !== a || w_log[idx].data !== d) begin
            errors++;
            $display("FAIL %s actual=x%0d:%h expected=x%0d:%h", name,
                     w_log[idx].addr, w_log[idx].data, a, d);
        end
    endtask

    function automatic logic m_haz(input logic [4:0] a);
        logic hit;
        hit = (a != 5'd0) && m_pend[a];
        foreach (m_q[i]) if (a != 5'd0 && m_q[i].addr == a) hit = 1'b1;
        return hit;
    endfunction

    // Reference behaviour at one clock edge: the head is written and leaves,
    // then the LSU result and an accepted ALU result join the tail.
    task automatic model_edge();
        type_scr1_wb_entry_s e;
        bit alu_ok;
        alu_ok = alu_wb_req_i && ((DEPTH - m_q.size()) >= 2);
        if (m_q.size() != 0) void'(m_q.pop_front());
        if (lsu_wb_req_i && lsu_wb_addr_i != 5'd0) begin
            e.addr = lsu_wb_addr_i; e.data = lsu_wb_data_i; m_q.push_back(e);
        end
        if (alu_ok && alu_wb_addr_i != 5'd0) begin
            e.addr = alu_wb_addr_i; e.data = alu_wb_data_i; m_q.push_back(e);
        end
        if (lsu_wb_req_i) m_pend[lsu_wb_addr_i] = 1'b0;
        if (ld_issue_i && ld_issue_addr_i != 5'd0) m_pend[ld_issue_addr_i] = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pend = 32'd0;
        end else begin
            model_edge();
        end
    end

    // Per-cycle comparison against the model, mid low phase.
    always @(negedge clk) begin
        #3;
        chk("m_w_req", mprf_w_req_o, (m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("m_rd_addr", mprf_rd_addr_o, m_q[0].addr);
            chk("m_rd_data", mprf_rd_data_o, m_q[0].data);
        end
        chk("m_alu_rdy", alu_wb_rdy_o, ((DEPTH - m_q.size()) >= 2));
        chk("m_rs1_haz", rs1_hazard_o, m_haz(rs1_addr_i));
        chk("m_rs2_haz", rs2_hazard_o, m_haz(rs2_addr_i));
        if (mprf_w_req_o === 1'b1) w_log.push_back({mprf_rd_addr_o, mprf_rd_data_o});
    end

    task automatic drv(input logic ar, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lr, input logic [4:0] la, input logic [31:0] ld,
                       input logic ir, input logic [4:0] ia);
        alu_wb_req_i = ar; alu_wb_addr_i = aa; alu_wb_data_i = ad;
        lsu_wb_req_i = lr; lsu_wb_addr_i = la; lsu_wb_data_i = ld;
        ld_issue_i = ir;   ld_issue_addr_i = ia;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Fill vectors: ALU request, ALU addr, LSU request, LSU addr, expected ready.
    logic       v_ar [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] v_aa [7] = '{5'd20, 5'd21, 5'd22, 5'd22, 5'd22, 5'd22, 5'd0};
    logic       v_lr [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] v_la [7] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd0, 5'd0, 5'd0};
    logic       v_rdy[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] s4_order [7] = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd13, 5'd22};

    initial begin
        int idx;
        rst_n = 1'b0;
        idle();
        rs1_addr_i = 5'd0;
        rs2_addr_i = 5'd0;

        // Reset state
        @(negedge clk); #4;
        chk("rst_w_req", mprf_w_req_o, 1'b0);
        chk("rst_addr", mprf_rd_addr_o, 5'd0);
        chk("rst_data", mprf_rd_data_o, 32'd0);
        chk("rst_rdy", alu_wb_rdy_o, 1'b1);
        @(negedge clk); rst_n = 1'b1;

        // ALU x5 = 0x1234 into empty queue
        @(negedge clk); drv(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); rs1_addr_i = 5'd5;
        #4; chk("s1_haz_before", rs1_hazard_o, 1'b0);
        @(negedge clk); idle();
        #4; chk("s1_w_req", mprf_w_req_o, 1'b1);
        chk("s1_addr", mprf_rd_addr_o, 5'd5);
        chk("s1_data", mprf_rd_data_o, 32'h1234);
        chk("s1_haz_queued", rs1_hazard_o, 1'b1);
        @(negedge clk); #4;
        chk("s1_w_req_done", mprf_w_req_o, 1'b0);
        chk("s1_haz_done", rs1_hazard_o, 1'b0);

        // LSU x3 = 0xA alongside ALU x4 = 0xB: LSU entry written first
        @(negedge clk); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3); rs1_addr_i = 5'd0;
        @(negedge clk); drv(1'b1, 5'd4, 32'hB, 1'b1, 5'd3, 32'hA, 1'b0, 5'd0);
        idx = w_log.size();
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk); #4;
        chk("s2_drained", mprf_w_req_o, 1'b0);
        chk_log("s2_first", idx, 5'd3, 32'hA);
        chk_log("s2_second", idx + 1, 5'd4, 32'hB);

        // Load x7 hazard until the returned data is written
        @(negedge clk); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7); rs2_addr_i = 5'd7;
        @(negedge clk); idle();
        #4; chk("s3_haz_pend", rs2_hazard_o, 1'b1);
        @(negedge clk); drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
        #4; chk("s3_haz_return", rs2_hazard_o, 1'b1);
        @(negedge clk); idle();
        #4; chk("s3_haz_queued", rs2_hazard_o, 1'b1);
        chk("s3_addr", mprf_rd_addr_o, 5'd7);
        chk("s3_data", mprf_rd_data_o, 32'h77);
        @(negedge clk); #4;
        chk("s3_haz_clear", rs2_hazard_o, 1'b0);
        rs2_addr_i = 5'd0;

        // Fill with back-to-back ALU writes plus LSU returns while draining
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + k));
        end
        @(negedge clk); idle();
        idx = w_log.size();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drv(v_ar[k], v_aa[k], 32'hA000 + 32'(v_aa[k]), v_lr[k], v_la[k], 32'hD000 + 32'(v_la[k]), 1'b0, 5'd0);
            #4; chk($sformatf("s4_rdy_%0d", k), alu_wb_rdy_o, v_rdy[k]);
        end
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            chk_log($sformatf("s4_order_%0d", k), idx + k, s4_order[k],
                    ((s4_order[k] >= 5'd20) ? 32'hA000 : 32'hD000) + 32'(s4_order[k]));
        end

        // Writes and load issues to x0 are swallowed
        idx = w_log.size();
        @(negedge clk); drv(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        #4; chk("s5_rdy", alu_wb_rdy_o, 1'b1);
        chk("s5_haz1", rs1_hazard_o, 1'b0);
        @(negedge clk); idle();
        #4; chk("s5_w_req", mprf_w_req_o, 1'b0);
        chk("s5_haz2", rs2_hazard_o, 1'b0);
        @(negedge clk); #4;
        chk("s5_nolog", w_log.size(), idx);

        // Asynchronous reset with three queued entries and x9 pending
        @(negedge clk); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        @(negedge clk); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd14);
        @(negedge clk); drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15);
        @(negedge clk); drv(1'b1, 5'd16, 32'h16, 1'b1, 5'd14, 32'h14, 1'b0, 5'd0);
        @(negedge clk); drv(1'b1, 5'd17, 32'h17, 1'b1, 5'd15, 32'h15, 1'b0, 5'd0);
        @(negedge clk); idle(); rs1_addr_i = 5'd9; rs2_addr_i = 5'd16;
        #1; chk("s6_pre_haz1", rs1_hazard_o, 1'b1);
        chk("s6_pre_haz2", rs2_hazard_o, 1'b1);
        chk("s6_pre_rdy", alu_wb_rdy_o, 1'b0);
        chk("s6_pre_addr", mprf_rd_addr_o, 5'd16);
        #1; rst_n = 1'b0;
        #2;
        chk("s6_rst_w_req", mprf_w_req_o, 1'b0);
        chk("s6_rst_addr", mprf_rd_addr_o, 5'd0);
        chk("s6_rst_data", mprf_rd_data_o, 32'd0);
        chk("s6_rst_rdy", alu_wb_rdy_o, 1'b1);
        chk("s6_rst_haz1", rs1_hazard_o, 1'b0);
        chk("s6_rst_haz2", rs2_hazard_o, 1'b0);
        idx = w_log.size();
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); #4;
            chk("s6_post_w_req", mprf_w_req_o, 1'b0);
            chk("s6_post_haz1", rs1_hazard_o, 1'b0);
        end
        chk("s6_nolog", w_log.size(), idx);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scr1_pipe_mprf_wb
